// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch-side consumer of the instruction pointer. Reads ip_cur, issues a
//   req/ack instruction-memory read, buffers fetched words in a DEPTH-entry
//   prefetch FIFO and presents them to decode under valid/ready. Pulses
//   inc_ip after each accepted fetch, and drives load_ip/ip_load_val on a
//   branch redirect while flushing stale prefetched words.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   ip_cur                 current IP value
//   inc_ip, load_ip        one-cycle IP advance / IP load pulses
//   ip_load_val            redirect target for the IP
//   mem_req, mem_addr      memory read request and address (held until ack)
//   mem_ack, mem_rdata     read completion and data
//   instr, instr_pc        FIFO head word and its address
//   instr_valid            FIFO non-empty
//   instr_ready            decode accepts the head word
//   redirect, redirect_pc  branch-taken pulse and target
//   stall_cnt              (IFU_STALL_CNT_EN only) cycles with instr_valid=0,
//                          saturating
//
// Build option
//   IFU_STALL_CNT_EN : adds the stall_cnt output and its counter.

module instruction_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ip_cur,
  output logic              inc_ip,
  output logic              load_ip,
  output logic [ADDR_W-1:0] ip_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DISCARD} state_t;

  state_t                         r_state;
  logic                           r_mem_req;
  logic [ADDR_W-1:0]              r_mem_addr;
  logic                           r_inc_ip;
  logic                           r_load_ip;
  logic [ADDR_W-1:0]              r_ip_load_val;
  logic [DEPTH-1:0][DATA_W-1:0]   r_data;
  logic [DEPTH-1:0][ADDR_W-1:0]   r_pc;
  logic [PW-1:0]                  r_wptr;
  logic [PW-1:0]                  r_rptr;
  logic [CW-1:0]                  r_count;

  logic w_pop;
  logic w_push;
  logic w_can_issue;

  assign inc_ip      = r_inc_ip;
  assign load_ip     = r_load_ip;
  assign ip_load_val = r_ip_load_val;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_data[r_rptr];
  assign instr_pc    = r_pc[r_rptr];
  assign instr_valid = (r_count != '0);

  assign w_pop  = instr_valid && instr_ready;
  assign w_push = (r_state == WAIT_ACK) && mem_ack && !redirect;

  // ip_cur only reflects an inc_ip/load_ip pulse one cycle after the pulse,
  // so hold off issuing while either pulse is still on the wire; otherwise
  // IDLE would fetch the stale address a second time.
  assign w_can_issue = !redirect && (r_count < FULL) && !r_inc_ip && !r_load_ip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_inc_ip      <= 1'b0;
      r_load_ip     <= 1'b0;
      r_ip_load_val <= '0;
      r_data        <= '0;
      r_pc          <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_inc_ip  <= 1'b0;
      r_load_ip <= 1'b0;
      if (redirect) begin
        r_load_ip     <= 1'b1;
        r_ip_load_val <= redirect_pc;
      end

      case (r_state)
        IDLE: begin
          if (w_can_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= ip_cur;
            r_state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (!redirect) r_inc_ip <= 1'b1;
          end else if (redirect) begin
            // An issued read cannot be withdrawn; let it finish and drop it.
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Flush takes priority over any same-cycle push or pop.
      if (redirect) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) begin
          r_data[r_wptr] <= mem_rdata;
          r_pc[r_wptr]   <= r_mem_addr;
          r_wptr         <= r_wptr + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef IFU_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!instr_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit. The driver plays the IP
// register, instruction memory and decoder; the monitor keeps a reference
// model (expected word queue, next fetch address, request generation) and
// compares DUT outputs at each falling edge.

module tb_instruction_fetch_unit;

  logic        clk, rst;
  logic [15:0] ip_cur;
  logic        inc_ip, load_ip;
  logic [15:0] ip_load_val;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr, instr_pc;
  logic        instr_valid, instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  instruction_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ip_cur(ip_cur), .inc_ip(inc_ip), .load_ip(load_ip),
    .ip_load_val(ip_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef IFU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents never have bit 15 set, so 16'hBEEF cannot occur naturally.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h1357) & 16'h7FFF;
  endfunction

  // ---------------- reference model / monitor ----------------
  typedef struct { logic [15:0] d; logic [15:0] a; } ent_t;
  ent_t        q[$];
  logic [15:0] next_pc = 16'h0000;
  logic [15:0] ip_nxt  = 16'h0000;
  logic [15:0] req_addr, last_req_addr;
  logic [15:0] exp_lval;
  logic        exp_inc = 1'b0, exp_load = 1'b0, prev_req = 1'b0;
  int          gen = 0, req_gen = 0;
  int          nreq = 0, ninc = 0, nbeef = 0;

  initial forever begin
    @(negedge clk);
    // The IP register samples inc_ip/load_ip at the next rising edge.
    ip_nxt = inc_ip ? ip_cur + 16'd1 : (load_ip ? ip_load_val : ip_cur);
    if (rst) begin
      q.delete();
      exp_inc  = 1'b0;
      exp_load = 1'b0;
      prev_req = 1'b0;
      next_pc  = ip_nxt;
      gen++;
      continue;
    end
    chk("inc_ip", inc_ip, exp_inc);
    chk("load_ip", load_ip, exp_load);
    if (exp_load) chk("ip_load_val", ip_load_val, exp_lval);
    chk("instr_valid", instr_valid, q.size() != 0);
    if (inc_ip) ninc++;
    if (instr_valid && instr == 16'hBEEF) nbeef++;

    if (mem_req && !prev_req) begin
      chk("mem_addr", mem_addr, next_pc);
      req_addr      = mem_addr;
      last_req_addr = mem_addr;
      req_gen       = gen;
      nreq++;
    end else if (mem_req) begin
      chk("mem_addr_hold", mem_addr, req_addr);
    end
    prev_req = mem_req;

    // Events sampled at the coming rising edge.
    exp_inc  = 1'b0;
    exp_load = 1'b0;
    if (instr_valid && instr_ready) begin
      chk("pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        ent_t e;
        e = q.pop_front();
        chk("instr", instr, e.d);
        chk("instr_pc", instr_pc, e.a);
      end
    end
    if (mem_req && mem_ack && !redirect && req_gen == gen) begin
      q.push_back('{mem_rdata, mem_addr});
      exp_inc = 1'b1;
      next_pc = next_pc + 16'd1;
    end
    if (redirect) begin
      q.delete();
      gen++;
      next_pc  = redirect_pc;
      exp_load = 1'b1;
      exp_lval = redirect_pc;
    end
  end

  // ---------------- environment driver ----------------
  int lat = 0, wcnt = 0;
  bit force_beef = 1'b0;

  task automatic step(input bit rnd);
    @(posedge clk); #1;
    ip_cur   = ip_nxt;
    redirect = 1'b0;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = force_beef ? 16'hBEEF : mem_word(mem_addr);
        if (force_beef) begin
          redirect    = 1'b1;
          redirect_pc = 16'h0200;
          force_beef  = 1'b0;
        end
        wcnt = rnd ? int'($urandom_range(0, 3)) : lat;
      end else begin
        wcnt--;
      end
    end
    if (rnd) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect    = 1'b1;
        redirect_pc = 16'($urandom);
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] ip0);
    step(0);
    rst      = 1'b1;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    wcnt     = 0;
    ip_cur   = ip0;
    step(0);
    step(0);
    rst = 1'b0;
  endtask

  task automatic wait_req(input int snap, input string nm);
    for (int i = 0; i < 20 && nreq == snap; i++) step(0);
    chk(nm, nreq != snap, 1);
  endtask

  int snap, isnap;
  logic [15:0] ip_snap;

  initial begin
    rst = 1'b1; ip_cur = 16'h0000; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inc_ip", inc_ip, 0);
    chk("rst_load_ip", load_ip, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_ip_load_val", ip_load_val, 0);
    step(0); step(0);
    rst = 1'b0;

    // Sequential fetch from 0000, ack one cycle after request.
    instr_ready = 1'b1;
    isnap = ninc;
    repeat (24) step(0);
    chk("seq_inc_count", ninc - isnap >= 6, 1);

    // Backpressure: exactly two fetches fill the FIFO.
    do_reset(16'h0000);
    instr_ready = 1'b0;
    snap = nreq;
    repeat (15) step(0);
    chk("bp_fetches", nreq - snap, 2);
    chk("bp_mem_req_idle", mem_req, 0);
    chk("bp_valid", instr_valid, 1);
    chk("bp_head_pc", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    isnap = ninc;
    repeat (12) step(0);
    chk("bp_resume", ninc - isnap >= 2, 1);

    // Redirect while idle with a full FIFO.
    instr_ready = 1'b0;
    repeat (12) step(0);
    chk("ri_full", instr_valid, 1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    step(0);
    chk("ri_load_ip", load_ip, 1);
    chk("ri_ip_load_val", ip_load_val, 16'h0040);
    chk("ri_valid_drop", instr_valid, 0);
    instr_ready = 1'b1;
    snap = nreq;
    wait_req(snap, "ri_req_seen");
    chk("ri_next_addr", last_req_addr, 16'h0040);

    // Redirect during WAIT_ACK, ack delayed 3 cycles.
    do_reset(16'h0010);
    instr_ready = 1'b1; wcnt = 3; lat = 3;
    snap = nreq;
    wait_req(snap, "wa_req_seen");
    redirect = 1'b1; redirect_pc = 16'h1234;
    isnap = ninc;
    step(0);
    chk("wa_mem_req_held", mem_req, 1);
    snap = nreq;
    wait_req(snap, "wa_next_req");
    chk("wa_no_inc", ninc - isnap, 0);
    chk("wa_next_addr", last_req_addr, 16'h1234);

    // Redirect coincident with mem_ack carrying BEEF.
    lat = 0;
    do_reset(16'h0020);
    instr_ready = 1'b1;
    force_beef = 1'b1;
    for (int i = 0; i < 10 && !mem_ack; i++) step(0);
    chk("bj_ack_seen", mem_ack, 1);
    step(0);
    chk("bj_inc_ip", inc_ip, 0);
    chk("bj_load_ip", load_ip, 1);
    chk("bj_ip_load_val", ip_load_val, 16'h0200);
    chk("bj_valid", instr_valid, 0);
    repeat (8) step(0);
    chk("bj_beef_never", nbeef, 0);

    // Asynchronous reset while waiting for an ack.
    do_reset(16'h0300);
    wcnt = 3; lat = 3;
    snap = nreq;
    wait_req(snap, "ar_req_seen");
    #2;
    rst = 1'b1;
    #1;
    chk("ar_mem_req", mem_req, 0);
    chk("ar_instr_valid", instr_valid, 0);
    chk("ar_inc_ip", inc_ip, 0);
    chk("ar_load_ip", load_ip, 0);
    mem_ack = 1'b0; wcnt = 0; lat = 0;
    step(0); step(0);
    rst = 1'b0;
    ip_snap = ip_cur;
    snap = nreq;
    wait_req(snap, "ar_req_after");
    chk("ar_first_addr", last_req_addr, ip_snap);

    // Randomized traffic.
    do_reset(16'($urandom));
    repeat (1500) step(1);
    instr_ready = 1'b1;
    repeat (10) step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
